// File: rtl/dmem_port_arbiter.sv
// Shares the single-ported data memory between the MEM stage and a debug port.
// CPU has priority; a pending debug request loses at most MAX_WAIT cycles.
module dmem_port_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_ack,
    output logic [AW-1:0] mem_address,
    output logic          mem_we,
    output logic [DW-1:0] mem_data,
    input  logic [DW-1:0] mem_q
);

    localparam logic [3:0] MW = 4'(MAX_WAIT);

    typedef enum logic {
        IDLE,
        DBG_ACK
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      wait_cnt_q, wait_cnt_d;
    logic            dbg_ack_q, dbg_ack_d;
    logic [DW-1:0]   dbg_rdata_q, dbg_rdata_d;
    logic            dbg_grant;

    // Grant is gated by rst_n so a reset mid-access drops mem_we at once.
    always_comb begin
        dbg_grant = rst_n && (state_q == IDLE) && dbg_req &&
                    (!cpu_req || (wait_cnt_q == MW));
    end

    always_comb begin
        mem_address = cpu_addr;
        mem_data    = cpu_wdata;
        mem_we      = cpu_req && cpu_we;
        if (dbg_grant) begin
            mem_address = dbg_addr;
            mem_data    = dbg_wdata;
            mem_we      = dbg_we;
        end
        if (!rst_n) begin
            mem_we = 1'b0;
        end
    end

    assign cpu_rdata = mem_q;
    assign cpu_stall = cpu_req && dbg_grant;
    assign dbg_ack   = dbg_ack_q;
    assign dbg_rdata = dbg_rdata_q;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        dbg_ack_d   = 1'b0;
        dbg_rdata_d = dbg_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (dbg_grant) begin
                    state_d     = DBG_ACK;
                    dbg_ack_d   = 1'b1;
                    dbg_rdata_d = mem_q;
                    wait_cnt_d  = 4'd0;
                end else if (dbg_req) begin
                    if (wait_cnt_q < MW) begin
                        wait_cnt_d = wait_cnt_q + 4'd1;
                    end
                end else begin
                    wait_cnt_d = 4'd0;
                end
            end
            DBG_ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wait_cnt_q  <= 4'd0;
            dbg_ack_q   <= 1'b0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            dbg_ack_q   <= dbg_ack_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: instance A uses MAX_WAIT=4,
// instance B uses MAX_WAIT=0; each owns its own 256x16 memory model.
module tb_dmem_port_arbiter;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [7:0]  cpu_addr, dbg_addr;
    logic [15:0] cpu_wdata, dbg_wdata;

    logic [15:0] cpu_rdata_a, dbg_rdata_a, mem_data_a, mem_q_a;
    logic [7:0]  mem_address_a;
    logic        cpu_stall_a, dbg_ack_a, mem_we_a;
    logic [15:0] cpu_rdata_b, dbg_rdata_b, mem_data_b, mem_q_b;
    logic [7:0]  mem_address_b;
    logic        cpu_stall_b, dbg_ack_b, mem_we_b;

    logic [15:0] mem_a [256];
    logic [15:0] mem_b [256];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (mem_we_a) mem_a[mem_address_a] <= mem_data_a;
        if (mem_we_b) mem_b[mem_address_b] <= mem_data_b;
    end
    assign mem_q_a = mem_a[mem_address_a];
    assign mem_q_b = mem_b[mem_address_b];

    dmem_port_arbiter #(.AW(8), .DW(16), .MAX_WAIT(4)) u_a (
        .clock(clock), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata_a), .cpu_stall(cpu_stall_a),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata_a), .dbg_ack(dbg_ack_a),
        .mem_address(mem_address_a), .mem_we(mem_we_a),
        .mem_data(mem_data_a), .mem_q(mem_q_a)
    );

    dmem_port_arbiter #(.AW(8), .DW(16), .MAX_WAIT(0)) u_b (
        .clock(clock), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata_b), .cpu_stall(cpu_stall_b),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata_b), .dbg_ack(dbg_ack_b),
        .mem_address(mem_address_b), .mem_we(mem_we_b),
        .mem_data(mem_data_b), .mem_q(mem_q_b)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Returns 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 8'h20;
        cpu_wdata = 16'h1111;
        dbg_req   = 1'b1;
        dbg_we    = 1'b1;
        dbg_addr  = 8'h21;
        dbg_wdata = 16'h2222;

        // Reset with every request high
        step();
        step();
        #1;
        chk("rst_mem_we_a", mem_we_a, 1'b0);
        chk("rst_mem_we_b", mem_we_b, 1'b0);
        chk("rst_ack_a", dbg_ack_a, 1'b0);
        chk("rst_rdata_a", dbg_rdata_a, 16'h0);
        chk("rst_stall_a", cpu_stall_a, 1'b0);
        chk("rst_stall_b", cpu_stall_b, 1'b0);
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        dbg_req = 1'b0;
        #1 rst_n = 1'b1;
        step();

        // No requester
        cpu_we   = 1'b1;
        cpu_addr = 8'h44;
        #1;
        chk("idle_mem_we", mem_we_a, 1'b0);
        chk("idle_addr", mem_address_a, 8'h44);
        cpu_we = 1'b0;

        // Uncontested debug write then read
        dbg_req   = 1'b1;
        dbg_we    = 1'b1;
        dbg_addr  = 8'h3C;
        dbg_wdata = 16'hBEEF;
        #1;
        chk("dw_mem_we", mem_we_a, 1'b1);
        chk("dw_addr", mem_address_a, 8'h3C);
        chk("dw_stall", cpu_stall_a, 1'b0);
        step();
        chk("dw_ack", dbg_ack_a, 1'b1);
        chk("dw_rdata", dbg_rdata_a, 16'hBEEF);
        dbg_req = 1'b0;
        step();
        chk("dw_ack_drop", dbg_ack_a, 1'b0);
        dbg_req = 1'b1;
        dbg_we  = 1'b0;
        #1;
        chk("dr_mem_we", mem_we_a, 1'b0);
        chk("dr_stall", cpu_stall_a, 1'b0);
        step();
        chk("dr_ack", dbg_ack_a, 1'b1);
        chk("dr_rdata", dbg_rdata_a, 16'hBEEF);
        dbg_req = 1'b0;
        step();

        // Contention, MAX_WAIT=4: CPU wins cycles 0..3
        cpu_req  = 1'b1;
        cpu_addr = 8'h3C;
        dbg_req  = 1'b1;
        dbg_addr = 8'h10;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("ct_stall_c%0d", k), cpu_stall_a, 1'b0);
            chk($sformatf("ct_addr_c%0d", k), mem_address_a, 8'h3C);
            chk($sformatf("ct_ack_c%0d", k), dbg_ack_a, 1'b0);
            step();
        end
        #1;
        chk("ct_stall_c4", cpu_stall_a, 1'b1);
        chk("ct_addr_c4", mem_address_a, 8'h10);
        step();
        chk("ct_ack_c5", dbg_ack_a, 1'b1);
        dbg_req = 1'b0;
        #1;
        chk("ct_stall_c5", cpu_stall_a, 1'b0);
        step();
        // Fresh request must start losing again (counter cleared)
        dbg_req = 1'b1;
        #1;
        chk("ct_new_stall", cpu_stall_a, 1'b0);
        step();
        dbg_req = 1'b0;
        cpu_req = 1'b0;
        step();
        step();

        // MAX_WAIT=0: CPU held, debug held; grant and ack alternate
        cpu_req  = 1'b1;
        cpu_addr = 8'h3C;
        dbg_req  = 1'b1;
        dbg_addr = 8'h3C;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("mw0_gstall_%0d", k), cpu_stall_b, 1'b1);
            chk($sformatf("mw0_gack_%0d", k), dbg_ack_b, 1'b0);
            step();
            chk($sformatf("mw0_ack_%0d", k), dbg_ack_b, 1'b1);
            chk($sformatf("mw0_ardata_%0d", k), dbg_rdata_b, 16'hBEEF);
            chk($sformatf("mw0_astall_%0d", k), cpu_stall_b, 1'b0);
            step();
        end
        dbg_req = 1'b0;
        cpu_req = 1'b0;
        step();
        step();

        // Reset during a debug write grant, before the negedge
        dbg_req   = 1'b1;
        dbg_we    = 1'b1;
        dbg_addr  = 8'h3C;
        dbg_wdata = 16'hAAAA;
        #1;
        chk("rg_mem_we_pre", mem_we_a, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rg_mem_we", mem_we_a, 1'b0);
        #4;
        chk("rg_mem_kept", mem_a[8'h3C], 16'hBEEF);
        step();
        chk("rg_ack", dbg_ack_a, 1'b0);
        dbg_req = 1'b0;
        #1 rst_n = 1'b1;
        step();
        chk("rg_ack_post", dbg_ack_a, 1'b0);
        dbg_req  = 1'b1;
        dbg_we   = 1'b0;
        cpu_addr = 8'h00;
        #1;
        chk("rg_idle_grant", mem_address_a, 8'h3C);
        step();
        chk("rg_rd_ack", dbg_ack_a, 1'b1);
        chk("rg_rd_data", dbg_rdata_a, 16'hBEEF);
        dbg_req = 1'b0;
        step();

        // CPU write with no debug activity
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 8'hFF;
        cpu_wdata = 16'h1234;
        #1;
        chk("cw_mem_we", mem_we_a, 1'b1);
        chk("cw_addr", mem_address_a, 8'hFF);
        chk("cw_data", mem_data_a, 16'h1234);
        chk("cw_stall", cpu_stall_a, 1'b0);
        #4;
        chk("cw_rdata", cpu_rdata_a, 16'h1234);
        step();
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
